// File: rtl/sc_cal_sequencer_pkg.sv
// Shared definitions for the special-command calibration sequencer.
// Holds the sequencer state encoding and the SC register word width.
package sc_cal_sequencer_pkg;

    localparam int SC_WORD_W = 32;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_SHIFT       = 4'd1,
        ST_LATCH       = 4'd2,
        ST_DELAY       = 4'd3,
        ST_TRIG        = 4'd4,
        ST_GAP         = 4'd5,
        ST_CLEAR_SHIFT = 4'd6,
        ST_CLEAR_LATCH = 4'd7,
        ST_DONE        = 4'd8
    } seq_state_t;

endpackage

// File: rtl/sc_cal_sequencer_serializer.sv
// MSB-first serializer driving the SC register serial port.
// A load restarts a full WORD_W-bit burst; zeros fill in behind the data.
module sc_cal_sequencer_serializer
    import sc_cal_sequencer_pkg::*;
#(
    parameter int WORD_W = SC_WORD_W
) (
    input  logic              bclk,
    input  logic              rstb,
    input  logic              en,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    output logic              shift_en,
    output logic              shift_in,
    output logic              last
);

    localparam int CW = $clog2(WORD_W);

    logic [WORD_W-1:0] shreg_reg;
    logic [WORD_W-1:0] shreg_next;
    logic [CW-1:0]     bit_cnt_reg;
    logic              active_reg;

    assign shreg_next[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < WORD_W; gi++) begin : g_shift
            assign shreg_next[gi] = shreg_reg[gi-1];
        end
    endgenerate

    assign last     = active_reg && (bit_cnt_reg == CW'(WORD_W - 1));
    assign shift_en = active_reg;
    assign shift_in = active_reg & shreg_reg[WORD_W-1];

    always_ff @(posedge bclk) begin
        if (!rstb) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            active_reg  <= 1'b0;
        end else if (en) begin
            if (load) begin
                // A load wins over an in-flight burst so abort restarts a full clear.
                shreg_reg   <= load_data;
                bit_cnt_reg <= '0;
                active_reg  <= 1'b1;
            end else if (active_reg) begin
                shreg_reg   <= shreg_next;
                bit_cnt_reg <= bit_cnt_reg + CW'(1);
                if (last) begin
                    active_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sc_cal_sequencer.sv
// Sequencer for the SC register serial load port: shift, repeated latch/trigger,
// then shift-and-latch zeros so the register is left cleared.
module sc_cal_sequencer
    import sc_cal_sequencer_pkg::*;
#(
    parameter int WORD_W = SC_WORD_W,
    parameter int CNT_W  = 16,
    parameter int DLY_W  = 8
) (
    input  logic              bclk,
    input  logic              rstb,
    input  logic              clkEn,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cmd_word,
    input  logic [CNT_W-1:0]  n_pulses,
    input  logic [DLY_W-1:0]  trig_delay,
    input  logic [CNT_W-1:0]  gap,
    output logic              sc_shiftEn,
    output logic              sc_shiftIn,
    output logic              sc_latchIn,
    output logic              sc_latchOut,
    output logic              l0_trig,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pulse_cnt
);

    seq_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  pulse_cnt_reg, pulse_cnt_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  n_reg;
    logic [DLY_W-1:0]  dly_reg;
    logic [CNT_W-1:0]  gap_reg;
    logic [CNT_W-1:0]  pulse_cnt_inc;
    logic              capture;
    logic              ser_load;
    logic [WORD_W-1:0] ser_data;
    logic              ser_last;
    logic              latch_int;
    logic              trig_int;
    logic              done_int;

    assign pulse_cnt_inc = (&pulse_cnt_reg) ? pulse_cnt_reg : pulse_cnt_reg + CNT_W'(1);

    always_comb begin
        state_next     = state_reg;
        pulse_cnt_next = pulse_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        capture        = 1'b0;
        ser_load       = 1'b0;
        ser_data       = '0;
        latch_int      = 1'b0;
        trig_int       = 1'b0;
        done_int       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    capture        = 1'b1;
                    pulse_cnt_next = '0;
                    if (n_pulses == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        ser_load   = 1'b1;
                        ser_data   = cmd_word;
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    ser_load   = 1'b1;
                    state_next = ST_CLEAR_SHIFT;
                end else if (ser_last) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                latch_int = 1'b1;
                if (abort) begin
                    ser_load   = 1'b1;
                    state_next = ST_CLEAR_SHIFT;
                end else if (dly_reg == '0) begin
                    state_next = ST_TRIG;
                end else begin
                    wait_cnt_next = CNT_W'(dly_reg) - CNT_W'(1);
                    state_next    = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (abort) begin
                    ser_load   = 1'b1;
                    state_next = ST_CLEAR_SHIFT;
                end else if (wait_cnt_reg == '0) begin
                    state_next = ST_TRIG;
                end else begin
                    wait_cnt_next = wait_cnt_reg - CNT_W'(1);
                end
            end
            ST_TRIG: begin
                trig_int       = 1'b1;
                pulse_cnt_next = pulse_cnt_inc;
                if (abort) begin
                    ser_load   = 1'b1;
                    state_next = ST_CLEAR_SHIFT;
                end else if (gap_reg != '0) begin
                    wait_cnt_next = gap_reg - CNT_W'(1);
                    state_next    = ST_GAP;
                end else if (pulse_cnt_inc < n_reg) begin
                    state_next = ST_LATCH;
                end else begin
                    ser_load   = 1'b1;
                    state_next = ST_CLEAR_SHIFT;
                end
            end
            ST_GAP: begin
                if (abort || (wait_cnt_reg == '0 && pulse_cnt_reg >= n_reg)) begin
                    ser_load   = 1'b1;
                    state_next = ST_CLEAR_SHIFT;
                end else if (wait_cnt_reg == '0) begin
                    // Re-latching the unchanged shifter re-arms the register edge detect.
                    state_next = ST_LATCH;
                end else begin
                    wait_cnt_next = wait_cnt_reg - CNT_W'(1);
                end
            end
            ST_CLEAR_SHIFT: begin
                if (ser_last) begin
                    state_next = ST_CLEAR_LATCH;
                end
            end
            ST_CLEAR_LATCH: begin
                latch_int  = 1'b1;
                done_int   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_DONE: begin
                done_int   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bclk) begin
        if (!rstb) begin
            state_reg     <= ST_IDLE;
            pulse_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            n_reg         <= '0;
            dly_reg       <= '0;
            gap_reg       <= '0;
        end else if (clkEn) begin
            state_reg     <= state_next;
            pulse_cnt_reg <= pulse_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            if (capture) begin
                n_reg   <= n_pulses;
                dly_reg <= trig_delay;
                gap_reg <= gap;
            end
        end
    end

    sc_cal_sequencer_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .bclk      (bclk),
        .rstb      (rstb),
        .en        (clkEn),
        .load      (ser_load),
        .load_data (ser_data),
        .shift_en  (sc_shiftEn),
        .shift_in  (sc_shiftIn),
        .last      (ser_last)
    );

    assign sc_latchIn  = latch_int & clkEn;
    assign l0_trig     = trig_int & clkEn;
    assign done        = done_int & clkEn;
    assign sc_latchOut = 1'b0;
    assign busy        = (state_reg != ST_IDLE);
    assign pulse_cnt   = pulse_cnt_reg;

endmodule

// File: tb/tb_sc_cal_sequencer.sv
// Directed plus randomized bench for sc_cal_sequencer with an event-schedule model
// and a behavioural model of the downstream SC register.
module tb_sc_cal_sequencer;

    localparam int MAXC = 1024;

    logic        bclk = 1'b0;
    logic        rstb = 1'b0;
    logic        clkEn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cmd_word = '0;
    logic [15:0] n_pulses = '0;
    logic [7:0]  trig_delay = '0;
    logic [15:0] gap = '0;
    logic        sc_shiftEn, sc_shiftIn, sc_latchIn, sc_latchOut;
    logic        l0_trig, busy, done;
    logic [15:0] pulse_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic exp_se [0:MAXC];
    logic exp_si [0:MAXC];
    logic exp_la [0:MAXC];
    logic exp_tr [0:MAXC];
    logic exp_dn [0:MAXC];
    logic exp_bs [0:MAXC];

    logic [31:0] sc_sr = '0;
    logic [31:0] sc_dout = '0;

    sc_cal_sequencer dut (
        .bclk        (bclk),
        .rstb        (rstb),
        .clkEn       (clkEn),
        .start       (start),
        .abort       (abort),
        .cmd_word    (cmd_word),
        .n_pulses    (n_pulses),
        .trig_delay  (trig_delay),
        .gap         (gap),
        .sc_shiftEn  (sc_shiftEn),
        .sc_shiftIn  (sc_shiftIn),
        .sc_latchIn  (sc_latchIn),
        .sc_latchOut (sc_latchOut),
        .l0_trig     (l0_trig),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 bclk = ~bclk;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Timeline of the run, one entry per enabled cycle after the start cycle.
    task automatic build(input logic [31:0] cmd, input int n, input int d, input int g,
                         input int abort_at, output int end_c);
        int  c;
        bit  ab;
        for (int i = 0; i <= MAXC; i++) begin
            exp_se[i] = 0; exp_si[i] = 0; exp_la[i] = 0;
            exp_tr[i] = 0; exp_dn[i] = 0; exp_bs[i] = 0;
        end
        c  = 0;
        ab = 0;
        if (n == 0) begin
            c = 1;
            exp_dn[1] = 1;
        end else begin
            for (int b = 0; b < 32 && !ab; b++) begin
                c++; exp_se[c] = 1; exp_si[c] = cmd[31-b]; ab = (c == abort_at);
            end
            for (int i = 0; i < n && !ab; i++) begin
                c++; exp_la[c] = 1; ab = (c == abort_at);
                for (int j = 0; j < d && !ab; j++) begin
                    c++; ab = (c == abort_at);
                end
                if (!ab) begin
                    c++; exp_tr[c] = 1; ab = (c == abort_at);
                end
                for (int j = 0; j < g && !ab; j++) begin
                    c++; ab = (c == abort_at);
                end
            end
            for (int b = 0; b < 32; b++) begin
                c++; exp_se[c] = 1;
            end
            c++; exp_la[c] = 1; exp_dn[c] = 1;
        end
        for (int i = 1; i <= c; i++) exp_bs[i] = 1;
        end_c = c;
    endtask

    task automatic run_seq(input string name, input logic [31:0] cmd, input int n,
                           input int d, input int g, input int abort_at, input int mode);
        int end_c, k, t, trigs, first_latch, first_trig;
        logic en;
        build(cmd, n, d, g, abort_at, end_c);
        @(negedge bclk);
        clkEn = 1; start = 1; abort = 0;
        cmd_word = cmd; n_pulses = 16'(n); trig_delay = 8'(d); gap = 16'(g);
        #1;
        chk1({name, "_idle_busy"}, busy, 1'b0);
        k = 1; t = 0; trigs = 0; first_latch = -1; first_trig = -1;
        while (k <= end_c && t < 4000) begin
            @(negedge bclk);
            start = 0;
            if (mode == 0)      en = 1'b1;
            else if (mode == 1) en = t[0];
            else                en = 1'($urandom_range(0, 1));
            clkEn = en;
            abort = en && (k == abort_at);
            #1;
            chk1({name, "_shiftEn"}, sc_shiftEn, exp_se[k]);
            chk1({name, "_busy"}, busy, exp_bs[k]);
            if (en) begin
                chk1({name, "_shiftIn"}, sc_shiftIn, exp_si[k]);
                chk1({name, "_latchIn"}, sc_latchIn, exp_la[k]);
                chk1({name, "_l0_trig"}, l0_trig, exp_tr[k]);
                chk1({name, "_done"}, done, exp_dn[k]);
                chk32({name, "_pulse_cnt"}, 32'(pulse_cnt), 32'(trigs));
                if (sc_shiftEn) sc_sr = {sc_sr[30:0], sc_shiftIn};
                if (sc_latchIn) begin
                    sc_dout = sc_sr;
                    if (first_latch < 0) first_latch = k;
                    if (!exp_dn[k]) chk32({name, "_dout_cmd"}, sc_dout, cmd);
                end
                if (l0_trig && first_trig < 0) first_trig = k;
                if (exp_tr[k]) trigs++;
                k++;
            end else begin
                chk1({name, "_latch_gated"}, sc_latchIn, 1'b0);
                chk1({name, "_trig_gated"}, l0_trig, 1'b0);
                chk1({name, "_done_gated"}, done, 1'b0);
            end
            t++;
        end
        if (k <= end_c) chk1({name, "_timeout"}, 1'b0, 1'b1);
        @(negedge bclk);
        clkEn = 1; abort = 0;
        #1;
        chk1({name, "_end_busy"}, busy, 1'b0);
        chk1({name, "_end_done"}, done, 1'b0);
        chk32({name, "_end_pulse_cnt"}, 32'(pulse_cnt), 32'(trigs));
        chk32({name, "_dout_clear"}, sc_dout, 32'h0);
        chk1({name, "_latchOut"}, sc_latchOut, 1'b0);
        if (n > 0 && abort_at < 0) begin
            chk32({name, "_first_latch_cyc"}, 32'(first_latch), 32'(33));
            chk32({name, "_first_trig_cyc"}, 32'(first_trig), 32'(34 + d));
            chk32({name, "_trig_total"}, 32'(trigs), 32'(n));
        end
        $display("run %s cmd=%08h n=%0d dly=%0d gap=%0d abort_at=%0d mode=%0d cycles=%0d trigs=%0d",
                 name, cmd, n, d, g, abort_at, mode, end_c, trigs);
    endtask

    initial begin
        repeat (3) @(negedge bclk);
        #1;
        chk1("rst_shiftEn", sc_shiftEn, 1'b0);
        chk1("rst_latchIn", sc_latchIn, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk32("rst_pulse_cnt", 32'(pulse_cnt), 32'h0);
        @(negedge bclk);
        rstb = 1;

        run_seq("t1_basic", 32'h0000_0001, 3, 4, 10, -1, 0);
        run_seq("t2_zero_dly", 32'hA5C3_0F1E, 2, 0, 0, -1, 0);
        run_seq("t3_n0", 32'hFFFF_FFFF, 0, 3, 3, -1, 0);
        run_seq("t4_abort", 32'h1234_5678, 3, 4, 10, 51, 0);
        run_seq("t5_clken_toggle", 32'h0000_0001, 3, 4, 10, -1, 1);

        // Reset in the middle of the shift burst.
        @(negedge bclk);
        clkEn = 1; start = 1; cmd_word = 32'hDEAD_BEEF; n_pulses = 16'd2;
        trig_delay = 8'd1; gap = 16'd1;
        repeat (10) begin
            @(negedge bclk);
            start = 0;
        end
        #1;
        chk1("t6_pre_busy", busy, 1'b1);
        rstb = 0;
        @(negedge bclk);
        rstb = 1;
        #1;
        chk1("t6_rst_shiftEn", sc_shiftEn, 1'b0);
        chk1("t6_rst_shiftIn", sc_shiftIn, 1'b0);
        chk1("t6_rst_latchIn", sc_latchIn, 1'b0);
        chk1("t6_rst_trig", l0_trig, 1'b0);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_done", done, 1'b0);
        chk32("t6_rst_pulse_cnt", 32'(pulse_cnt), 32'h0);
        run_seq("t6_after_rst", 32'hC0FF_EE00, 2, 1, 2, -1, 0);

        for (int r = 0; r < 8; r++) begin
            int n, d, g, ab, mode;
            n    = $urandom_range(0, 4);
            d    = $urandom_range(0, 5);
            g    = $urandom_range(0, 5);
            mode = $urandom_range(0, 2);
            ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : -1;
            run_seq($sformatf("rnd%0d", r), $urandom, n, d, g, ab, mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
